// File: rtl/wb_periph_timer.sv
// Wishbone timer/compare peripheral: prescaled 32-bit up-counter with compare match,
// one-shot or auto-reload, and a level interrupt cleared by eoi or a STATUS write.
module wb_periph_timer #(
  parameter int          PRESC_W   = 16,
  parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_irq,
  input  logic        i_eoi
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PRESC  = 3'd1;
  localparam logic [2:0] REG_CMP    = 3'd2;
  localparam logic [2:0] REG_CNT    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  logic               en;
  logic               auto_rld;
  logic               irq_en;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic [31:0]        cmp;
  logic [31:0]        cnt;
  logic               pend;

  logic        accept;
  logic        wr;
  logic        rd;
  logic [2:0]  reg_sel;
  logic [31:0] wmask;
  logic        tick;
  logic        match;
  logic        w1c;
  logic [31:0] rd_val;
  logic [31:0] presc_ext;
  logic [31:0] presc_new;
  logic        unused_addr;

  assign o_wb_stall  = 1'b0;
  assign accept      = i_wb_cyc & i_wb_stb;
  assign wr          = accept & i_wb_we;
  assign rd          = accept & ~i_wb_we;
  assign reg_sel     = i_wb_addr[4:2];
  assign unused_addr = ^{i_wb_addr[31:5], i_wb_addr[1:0]};
  assign wmask       = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign presc_ext   = 32'(presc);
  assign presc_new   = (presc_ext & ~wmask) | (i_wb_data & wmask);

  // A tick fires on the clock where the prescaler count reaches PRESC
  assign tick  = en && (pcnt == presc);
  assign match = tick && (cnt == cmp);
  assign w1c   = wr && (reg_sel == REG_STATUS) && i_wb_sel[0] && i_wb_data[0];

  always_comb begin
    rd_val = 32'd0;
    case (reg_sel)
      REG_CTRL:   rd_val = {29'd0, irq_en, auto_rld, en};
      REG_PRESC:  rd_val = presc_ext;
      REG_CMP:    rd_val = cmp;
      REG_CNT:    rd_val = cnt;
      REG_STATUS: rd_val = {31'd0, pend};
      default:    rd_val = 32'd0;
    endcase
  end

  // Later assignments in this block take priority: CPU writes override the counter engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      auto_rld  <= 1'b0;
      irq_en    <= 1'b0;
      presc     <= '0;
      pcnt      <= '0;
      cmp       <= CMP_RESET;
      cnt       <= 32'd0;
      pend      <= 1'b0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= 32'd0;
      o_irq     <= 1'b0;
    end else begin
      o_wb_ack <= accept;
      o_irq    <= pend & irq_en;
      if (rd) o_wb_data <= rd_val;

      if (!en || tick) pcnt <= '0;
      else             pcnt <= pcnt + 1'b1;

      if (tick) begin
        if (cnt == cmp) begin
          if (auto_rld) cnt <= 32'd0;
          else          en  <= 1'b0;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end

      if (i_eoi || w1c) pend <= 1'b0;
      if (match)        pend <= 1'b1;

      if (wr) begin
        case (reg_sel)
          REG_CTRL: begin
            if (i_wb_sel[0]) begin
              en       <= i_wb_data[0];
              auto_rld <= i_wb_data[1];
              irq_en   <= i_wb_data[2];
            end
          end
          REG_PRESC: begin
            presc <= presc_new[PRESC_W-1:0];
            pcnt  <= '0;
          end
          REG_CMP: cmp <= (cmp & ~wmask) | (i_wb_data & wmask);
          REG_CNT: begin
            cnt  <= (cnt & ~wmask) | (i_wb_data & wmask);
            pcnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_periph_timer.sv
// Self-checking bench for wb_periph_timer: randomized timer setups checked against
// closed-form match times and counter values derived from the prescale/compare rules.
module tb_wb_periph_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_addr = 32'd0;
  logic [31:0] wb_wdata = 32'd0;
  logic [3:0]  wb_sel = 4'd0;
  logic        eoi = 1'b0;
  logic        wb_stall;
  logic        wb_ack;
  logic [31:0] wb_rdata;
  logic        irq;

  int cyc_n = 0;
  int total = 0;
  int passed = 0;

  wb_periph_timer #(.PRESC_W(16), .CMP_RESET(32'hFFFF_FFFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wb_cyc   (wb_cyc),
    .i_wb_stb   (wb_stb),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_wdata),
    .i_wb_sel   (wb_sel),
    .o_wb_stall (wb_stall),
    .o_wb_ack   (wb_ack),
    .o_wb_data  (wb_rdata),
    .o_irq      (irq),
    .i_eoi      (eoi)
  );

  always #5 clk = ~clk;

  // Edge counter lets tests reason about absolute acceptance edges
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic bus(input bit w, input int r, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] q, output logic a, output int e);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = w;
    wb_addr = 32'(r) << 2; wb_wdata = d; wb_sel = s;
    @(posedge clk); #1;
    e = cyc_n; a = wb_ack; q = wb_rdata;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input int r, input logic [31:0] d, input logic [3:0] s, output int e);
    logic [31:0] q; logic a;
    bus(1'b1, r, d, s, q, a, e);
  endtask

  task automatic rd(input int r, output logic [31:0] q, output int e);
    logic a;
    bus(1'b0, r, 32'd0, 4'd0, q, a, e);
  endtask

  task automatic wait_irq_rise(input int limit, output int rise, output bit found);
    found = 1'b0; rise = -1;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin rise = cyc_n; found = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_v [6];
    int          regs  [6];
    logic [31:0] q; logic a; int e;
    exp_v = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    regs  = '{0, 1, 2, 3, 4, 7};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({wb_ack, irq, wb_stall} !== 3'b000 || wb_rdata !== 32'd0)
      $display("[TB] FAIL reset_outputs got ack=%b irq=%b stall=%b data=%h exp 0", wb_ack, irq, wb_stall, wb_rdata);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus(1'b0, regs[i], 32'd0, 4'd0, q, a, e);
      total++;
      if (a !== 1'b1 || q !== exp_v[i])
        $display("[TB] FAIL reset_read reg%0d got ack=%b data=%h exp ack=1 data=%h", regs[i], a, q, exp_v[i]);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (wb_ack !== 1'b0) $display("[TB] FAIL ack_single reg%0d got %b exp 0", regs[i], wb_ack);
      else passed++;
    end
  endtask

  task automatic test_auto_reload();
    int p, c, per, e, r, x, rise; bit found;
    logic [31:0] q;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin p = 3; c = 4; end
      else begin p = $urandom_range(1, 4); c = $urandom_range(2, 5); end
      per = (c + 1) * (p + 1);
      wr(0, 32'd0, 4'hF, e); wr(1, 32'(p), 4'hF, e); wr(2, 32'(c), 4'hF, e);
      wr(3, 32'd0, 4'hF, e); wr(4, 32'd1, 4'hF, e);
      wr(0, 32'd7, 4'hF, e);
      wait_irq_rise(per + 10, rise, found);
      total++;
      if (!found || rise != e + per + 1)
        $display("[TB] FAIL auto_first_irq p=%0d c=%0d got %0d exp %0d", p, c, rise - e, per + 1);
      else passed++;
      @(negedge clk); eoi = 1'b1;
      @(posedge clk); #1; x = cyc_n; eoi = 1'b0;
      total++;
      if (irq !== 1'b1) $display("[TB] FAIL eoi_irq_hold got %b exp 1", irq);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (irq !== 1'b0) $display("[TB] FAIL eoi_irq_drop got %b exp 0", irq);
      else passed++;
      rd(3, q, r);
      total++;
      if (q !== 32'(((r - 1 - e) / (p + 1)) % (c + 1)))
        $display("[TB] FAIL auto_cnt got %0d exp %0d", q, ((r - 1 - e) / (p + 1)) % (c + 1));
      else passed++;
      wait_irq_rise(2 * per, rise, found);
      total++;
      if (!found || rise != e + 2 * per + 1)
        $display("[TB] FAIL auto_second_irq p=%0d c=%0d got %0d exp %0d", p, c, rise - e, 2 * per + 1);
      else passed++;
      wr(0, 32'd0, 4'hF, e); wr(4, 32'd1, 4'hF, e);
    end
  endtask

  task automatic test_one_shot();
    int p, c, per, e, w, rise; bit found;
    logic [31:0] q;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin p = 0; c = 2; end
      else begin p = $urandom_range(0, 3); c = $urandom_range(0, 5); end
      per = (c + 1) * (p + 1);
      wr(0, 32'd0, 4'hF, e); wr(1, 32'(p), 4'hF, e); wr(2, 32'(c), 4'hF, e);
      wr(3, 32'd0, 4'hF, e); wr(4, 32'd1, 4'hF, e);
      wr(0, 32'd5, 4'hF, e);
      wait_irq_rise(per + 10, rise, found);
      total++;
      if (!found || rise != e + per + 1)
        $display("[TB] FAIL oneshot_irq p=%0d c=%0d got %0d exp %0d", p, c, rise - e, per + 1);
      else passed++;
      rd(0, q, w);
      total++;
      if (q !== 32'd4) $display("[TB] FAIL oneshot_ctrl got %h exp 4", q);
      else passed++;
      rd(3, q, w);
      total++;
      if (q !== 32'(c)) $display("[TB] FAIL oneshot_cnt got %0d exp %0d", q, c);
      else passed++;
      wr(4, 32'd1, 4'h1, w);
      repeat (2 * per + 4) @(posedge clk);
      #1;
      rd(4, q, w);
      total++;
      if (q !== 32'd0 || irq !== 1'b0)
        $display("[TB] FAIL oneshot_no_repend got status=%h irq=%b exp 0 0", q, irq);
      else passed++;
      rd(3, q, w);
      total++;
      if (q !== 32'(c)) $display("[TB] FAIL oneshot_cnt_hold got %0d exp %0d", q, c);
      else passed++;
    end
  endtask

  task automatic test_byte_wrap();
    logic [31:0] q, v, d, expv; logic [3:0] s; int e, r;
    wr(0, 32'd0, 4'hF, e);
    wr(3, 32'hFFFF_FFFE, 4'hF, e);
    wr(2, 32'hFFFF_FFFF, 4'hF, e);
    wr(2, 32'h0000_0010, 4'h1, e);
    rd(2, q, e);
    total++;
    if (q !== 32'hFFFF_FF10) $display("[TB] FAIL byte_cmp got %h exp FFFFFF10", q);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      v = $urandom; d = $urandom; s = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) expv[b*8 +: 8] = s[b] ? d[b*8 +: 8] : v[b*8 +: 8];
      wr(2, v, 4'hF, e); wr(2, d, s, e); rd(2, q, e);
      total++;
      if (q !== expv) $display("[TB] FAIL byte_merge sel=%b got %h exp %h", s, q, expv);
      else passed++;
    end
    wr(2, 32'hFFFF_FF10, 4'hF, e);
    wr(1, 32'd0, 4'hF, e); wr(4, 32'd1, 4'hF, e);
    wr(0, 32'd5, 4'hF, e);
    for (int i = 0; i < 4; i++) begin
      rd(3, q, r);
      total++;
      if (q !== 32'hFFFF_FFFE + 32'(r - 1 - e))
        $display("[TB] FAIL wrap_cnt got %h exp %h", q, 32'hFFFF_FFFE + 32'(r - 1 - e));
      else passed++;
    end
    rd(4, q, r);
    total++;
    if (q !== 32'd0 || irq !== 1'b0) $display("[TB] FAIL wrap_no_pend got status=%h irq=%b exp 0 0", q, irq);
    else passed++;
    wr(0, 32'd0, 4'hF, e);
  endtask

  task automatic test_collisions();
    logic [31:0] q; int e, w;
    wr(0, 32'd0, 4'hF, e); wr(1, 32'd0, 4'hF, e); wr(2, 32'd5, 4'hF, e);
    wr(3, 32'd5, 4'hF, e); wr(4, 32'd1, 4'hF, e);
    wr(0, 32'd3, 4'hF, e);
    eoi = 1'b1;
    wr(4, 32'd1, 4'h1, w);
    eoi = 1'b0;
    rd(4, q, w);
    total++;
    if (q !== 32'd1) $display("[TB] FAIL set_beats_clear got %h exp 1", q);
    else passed++;
    wr(3, 32'h100, 4'hF, w);
    rd(3, q, w);
    total++;
    if (q !== 32'h100) $display("[TB] FAIL cnt_write_vs_tick got %h exp 100", q);
    else passed++;
    rd(3, q, w);
    total++;
    if (q !== 32'h101) $display("[TB] FAIL cnt_after_write got %h exp 101", q);
    else passed++;
    wr(0, 32'd0, 4'hF, e); wr(4, 32'd1, 4'hF, e);
    wr(2, 32'd0, 4'hF, e); wr(3, 32'd0, 4'hF, e);
    wr(0, 32'd1, 4'hF, e);
    wr(0, 32'd1, 4'hF, e);
    rd(0, q, w);
    total++;
    if (q !== 32'd1) $display("[TB] FAIL ctrl_write_vs_oneshot got %h exp 1", q);
    else passed++;
    wr(0, 32'd0, 4'hF, e); wr(4, 32'd1, 4'hF, e);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, pv, exp_v [4];
    int regs [4]; int e;
    v = $urandom; pv = 32'($urandom_range(0, 65535));
    wr(2, v, 4'hF, e); wr(1, pv, 4'hF, e);
    regs  = '{2, 1, 2, 6};
    exp_v = '{v, pv, v, 32'd0};
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_addr = 32'(regs[i]) << 2;
      @(posedge clk); #1;
      total++;
      if (wb_ack !== 1'b1 || wb_rdata !== exp_v[i])
        $display("[TB] FAIL b2b_read%0d got ack=%b data=%h exp ack=1 data=%h", i, wb_ack, wb_rdata, exp_v[i]);
      else passed++;
    end
    wb_cyc = 1'b0;
    @(posedge clk); #1;
    total++;
    if (wb_ack !== 1'b0) $display("[TB] FAIL cyc_drop_ack got %b exp 0", wb_ack);
    else passed++;
    wb_stb = 1'b0;
  endtask

  task automatic test_mask_reset();
    logic [31:0] q; int e, w;
    logic [31:0] exp_v [5];
    exp_v = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    wr(0, 32'd0, 4'hF, e); wr(1, 32'd0, 4'hF, e); wr(2, 32'd0, 4'hF, e);
    wr(3, 32'd0, 4'hF, e); wr(4, 32'd1, 4'hF, e);
    wr(0, 32'd1, 4'hF, e);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (irq !== 1'b0) $display("[TB] FAIL masked_irq got %b exp 0", irq);
    else passed++;
    rd(4, q, w);
    total++;
    if (q !== 32'd1) $display("[TB] FAIL masked_pend got %h exp 1", q);
    else passed++;
    wr(0, 32'd4, 4'hF, w);
    total++;
    if (irq !== 1'b0) $display("[TB] FAIL unmask_early got %b exp 0", irq);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) $display("[TB] FAIL unmask_irq got %b exp 1", irq);
    else passed++;
    wr(2, 32'h1234_5678, 4'hF, w);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h8;
    @(posedge clk); #1;
    total++;
    if (wb_ack !== 1'b1 || wb_rdata !== 32'h1234_5678)
      $display("[TB] FAIL burst_pre_reset got ack=%b data=%h exp 1 12345678", wb_ack, wb_rdata);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (wb_ack !== 1'b0 || irq !== 1'b0 || wb_rdata !== 32'd0)
      $display("[TB] FAIL async_reset got ack=%b irq=%b data=%h exp 0 0 0", wb_ack, irq, wb_rdata);
    else passed++;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(i, q, w);
      total++;
      if (q !== exp_v[i]) $display("[TB] FAIL post_reset reg%0d got %h exp %h", i, q, exp_v[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_byte_wrap();
    test_collisions();
    test_back_to_back();
    test_mask_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
